apb_conv_master: RTL
====================

# apb_conv_master

APB initiator that issues the register traffic the convolution peripheral expects: filter-word writes, input-row writes, start-bit writes and status polls. Software or a local sequencer pushes commands into a small FIFO. The block then drives a compliant two-phase APB transfer for each command and honours PREADY wait states. Poll commands re-read a register until a masked bit pattern appears or a retry limit expires. It sits between the command source and the APB segment that hosts the convolution slave.

## Interface
Parameters:
- ADDR_W, 32, PADDR width
- DATA_W, 32, PWDATA/PRDATA width
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two, ≥2
- POLL_LIMIT, 1024, maximum read attempts per poll command; must be ≥1

Ports:
- HCLK  in  1  clock; all logic on the rising edge
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full; 0 while HRESET is high
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_write  in  1  1 = write, 0 = read
- cmd_poll  in  1  read only: repeat until (PRDATA & cmd_mask) == cmd_mask; ignored when cmd_write=1
- cmd_mask  in  DATA_W  poll mask
- rsp_valid  out  1  one-cycle completion pulse, one per command
- rsp_rdata  out  DATA_W  last PRDATA; 0 for writes
- rsp_err  out  1  PSLVERR was sampled on the completing access
- rsp_timeout  out  1  poll reached POLL_LIMIT without a match
- busy  out  1  FIFO non-empty or a transfer is in flight
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PWRITE  out  1; PSEL  out  1; PENABLE  out  1
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1

## Operation
- A handshake occurs when cmd_valid && cmd_ready. The command is pushed into the FIFO, which stores {addr, wdata, write, poll, mask}.
- FSM states: IDLE, SETUP, ACCESS, GAP.
  - IDLE → SETUP when the FIFO is non-empty. The head entry is popped into the transfer registers.
  - SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1. On completion:
    - Writes, plain reads, PSLVERR=1, poll matched, or poll attempt count = POLL_LIMIT: issue the response. Then → SETUP if the FIFO is non-empty (back-to-back), else → IDLE.
    - Poll not matched and below the limit: → GAP.
  - GAP: PSEL=0 for one cycle, then → SETUP with the same address.
- PSLVERR aborts a poll immediately. The response has rsp_err=1 and rsp_timeout=0.
- The poll attempt counter is sized by $clog2(POLL_LIMIT+1). It is cleared when a command is loaded.
- PADDR, PWRITE and PWDATA are registered. They are stable from SETUP through the end of ACCESS and hold their last values while idle.
- Responses carry no backpressure. rsp_* fields are valid only while rsp_valid=1 and are 0 otherwise.
- Simultaneous push and pop while full: cmd_ready=0, so the push is not taken. Push into an empty FIFO while IDLE: the command is popped on the next cycle.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_* and busy are all 0. The FIFO is empty and the FSM is in IDLE.
- Relative to a command accepted into an empty FIFO at cycle t (PREADY=1):
  - SETUP at t+1
  - ACCESS at t+2
  - rsp_valid at t+3
- Each PREADY wait state adds one cycle.
- Back-to-back commands: the next SETUP directly follows the completing ACCESS. Sustained throughput is one transfer per 2 cycles.
- Unmatched poll iteration costs 3 cycles (GAP, SETUP, ACCESS) plus wait states.
- rsp_valid is registered. It asserts the cycle after the ACCESS cycle with PREADY=1.
- HRESET mid-transfer: PSEL and PENABLE are 0 from the next edge, the FIFO is flushed, and no response is issued for the aborted or queued commands.

## Structure
- Package conv_apb_pkg contains:
  - state enum
  - command struct
  - peripheral address constants: CTRL 0x1A10_3500, STATUS 0x1A10_3504, DATA 0x1A10_3508, FILT0/1/2 0x1A10_3900/3904/3908
  - status bit indices: ROW_DONE=1, CHAN_DONE=2
- Sub-module apb_cmd_fifo: synchronous FIFO, parameterised on width and depth, with full and empty flags.

## Test plan
- Single write to 0x1A10_3900 with data 0x1234_5678 and PREADY=1 → PSEL at t+1, PENABLE at t+2, one rsp_valid at t+3 with rsp_err=0.
- Write with PREADY low for 3 ACCESS cycles → PADDR and PWDATA held stable, rsp_valid at t+6.
- Poll 0x1A10_3504 with mask 0x2, slave returns 0, 0, then 0x2 → exactly 3 reads, each separated by one GAP cycle; rsp_rdata=0x2, rsp_timeout=0.
- Poll with POLL_LIMIT=4 and the slave always returning 0 → 4 reads, then rsp_timeout=1.
- PSLVERR=1 on the second poll read → the poll stops, rsp_err=1, and no further reads are issued.
- Push 5 commands with FIFO_DEPTH=4 while the slave stalls → cmd_ready drops after 4 entries. All 5 complete in order with SETUP back-to-back after each ACCESS. Then assert HRESET during an ACCESS → PSEL=0 on the next cycle, busy=0, and no stale rsp_valid.

Source files
------------

// File: rtl/conv_apb_pkg.sv
// Shared types and register map for the convolution peripheral APB initiator.
package conv_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_GAP    = 2'd3
  } apb_state_e;

  // Command as seen by software at the default 32-bit widths.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        poll;
    logic [31:0] mask;
  } conv_cmd_t;

  localparam logic [31:0] CTRL_ADDR   = 32'h1A10_3500;
  localparam logic [31:0] STATUS_ADDR = 32'h1A10_3504;
  localparam logic [31:0] DATA_ADDR   = 32'h1A10_3508;
  localparam logic [31:0] FILT0_ADDR  = 32'h1A10_3900;
  localparam logic [31:0] FILT1_ADDR  = 32'h1A10_3904;
  localparam logic [31:0] FILT2_ADDR  = 32'h1A10_3908;

  localparam int ROW_DONE  = 1;
  localparam int CHAN_DONE = 2;

  function automatic logic [31:0] status_mask(input int bit_idx);
    return 32'd1 << bit_idx;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on rdata_o.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_conv_master.sv
// APB initiator: queued writes, reads and masked status polls toward the convolution slave.
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; rsp_valid is a pulse with no backpressure.
module apb_conv_master
  import conv_apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state_o
);

  localparam int CMD_W = ADDR_W + 2*DATA_W + 2;
  localparam int CNT_W = $clog2(POLL_LIMIT+1);
  localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(POLL_LIMIT-1);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mask_q, mask_d;
  logic              write_q, write_d, poll_q, poll_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CMD_W-1:0] cmd_in, fifo_head, next_cmd;
  logic             cmd_accept, next_avail, load;
  logic             match, last_try, finish;

  assign cmd_ready  = !fifo_full && !HRESET;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign cmd_in     = {cmd_addr, cmd_wdata, cmd_write, cmd_poll, cmd_mask};

  // An empty FIFO is bypassed so a command offered while idle reaches SETUP on the next edge.
  assign next_cmd   = fifo_empty ? cmd_in : fifo_head;
  assign next_avail = !fifo_empty || cmd_accept;
  assign fifo_pop   = load && !fifo_empty;
  assign fifo_push  = cmd_accept && !(load && fifo_empty);

  assign match    = ((PRDATA & mask_q) == mask_q);
  assign last_try = (cnt_q == LAST_TRY);
  assign finish   = write_q || !poll_q || PSLVERR || match || last_try;

  apb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    poll_d        = poll_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    load          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (next_avail) begin
          load    = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (finish) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = write_q ? '0 : PRDATA;
            rsp_err_d     = PSLVERR;
            rsp_timeout_d = !(write_q || !poll_q || PSLVERR || match);
            if (next_avail) begin
              load    = 1'b1;
              state_d = ST_SETUP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_SETUP;
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      {addr_d, wdata_d, write_d, poll_d, mask_d} = next_cmd;
      cnt_d = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      poll_q        <= 1'b0;
      mask_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      poll_q        <= poll_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign PWRITE      = write_q;
  assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state_o = state_q;

endmodule
